regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, meaning number of writeback requesters (0=ALU, 1=LSU, 2=MUL).
REQ-002 SHALL have parameter DATA_W, default 32, meaning writeback data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: req_valid  in  NUM_REQ  per-requester writeback request.
REQ-007 Port: req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
REQ-008 Port: req_rd  in  5*NUM_REQ  destination register, requester i in bits [5i+4:5i].
REQ-009 Port: req_wdata  in  DATA_W*NUM_REQ  write data, requester i in bits [DATA_W*i+DATA_W-1:DATA_W*i].
REQ-010 Port: resv_valid  in  1  issue stage requests reservation of resv_rd.
REQ-011 Port: resv_rd  in  5  destination register to reserve.
REQ-012 Port: resv_ready  out  1  reservation accepted this cycle.
REQ-013 Port: flush  in  1  clear all reservations.
REQ-014 Port: rs1, rs2  in  5 each  scoreboard query addresses.
REQ-015 Port: rs1_busy, rs2_busy  out  1 each  queried register has a pending write.
REQ-016 Port: busy_vec  out  32  scoreboard state, bit n = register n pending.
REQ-017 Port: rf_en, rf_rd, rf_wdata  out  1, 5, DATA_W  registered write port driving the register file en/rd/wdata.

Function
REQ-018 Arbitration SHALL be round-robin: the priority pointer ptr (0..NUM_REQ-1) gives the highest-priority index, and the search proceeds upward with wrap.
REQ-019 req_ready SHALL be combinational and at most one-hot: asserted only for the selected requester with req_valid=1.
REQ-020 A handshake SHALL be defined as req_valid[i] && req_ready[i], with at most one handshake per cycle.
REQ-021 On a handshake, ptr SHALL become (i+1) mod NUM_REQ at the next edge; with no handshake, ptr SHALL be unchanged.
REQ-022 Write-port latency SHALL be 1 cycle: a handshake in cycle N drives rf_en=1, rf_rd=req_rd[i] and rf_wdata=req_wdata[i] in cycle N+1.
REQ-023 With no handshake in cycle N, rf_en SHALL be 0 in cycle N+1, and rf_rd/rf_wdata SHALL hold their previous values.
REQ-024 A handshake with req_rd[i]=0 SHALL be accepted and dropped: rf_en=0 the next cycle and no scoreboard change.
REQ-025 resv_ready SHALL equal resv_valid && (resv_rd==0 || !busy_vec[resv_rd]) && !flush.
REQ-026 An accepted reservation with resv_rd!=0 SHALL set busy_vec[resv_rd] at the next edge; resv_rd=0 SHALL never set bit 0.
REQ-027 A handshake with rd!=0 SHALL clear busy_vec[rd] at the next edge, whether or not the bit was set.
REQ-028 When a set and a clear target the same register in one cycle, set SHALL win.
REQ-029 flush=1 SHALL clear all busy_vec bits at the next edge and override same-cycle sets; it SHALL NOT affect ptr, arbitration, or the rf_* pipeline register.
REQ-030 rs1_busy/rs2_busy SHALL be combinational reads of busy_vec from current state, with no same-cycle bypass, and SHALL be 0 for address 0.
REQ-031 busy_vec[0] SHALL always be 0.

Reset
REQ-032 Asserting rst low SHALL immediately force ptr=0, busy_vec=0, rf_en=0, rf_rd=0 and rf_wdata=0.
REQ-033 While rst is low, req_ready and resv_ready SHALL be 0.
REQ-034 A writeback accepted in the cycle before reset asserts SHALL be lost: no rf_en pulse after reset releases.
REQ-035 The first cycle after rst deasserts SHALL arbitrate with ptr=0.

Verification
REQ-036 Reservation/writeback: resv rd=5 -> busy_vec[5]=1 next cycle; then req_valid=001, rd=5, wdata=0xDEADBEEF -> req_ready=001, next cycle rf_en=1, rf_rd=5, rf_wdata=0xDEADBEEF, busy_vec[5]=0.
REQ-037 Round-robin fairness: req_valid=111 held for 6 cycles from reset -> grant order 0,1,2,0,1,2 with exactly one rf_en pulse per cycle.
REQ-038 WAW hazard: busy_vec[7]=1 and resv rd=7 -> resv_ready=0; the same cycle as writeback rd=7 -> still 0; the next cycle -> 1.
REQ-039 Set-wins and rd=0: unreserved writeback rd=9 coincident with reservation rd=9 -> busy_vec[9]=1; writeback rd=0 -> req_ready=1, rf_en=0 next cycle.
REQ-040 Flush and reset: busy_vec=0x0000_00F0 with flush=1 and resv rd=3 -> resv_ready=0, busy_vec=0 next cycle; rst low mid-burst -> all outputs 0 immediately, no stale rf_en after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding a register-file write port, combined with
// a 32-entry pending-write scoreboard that the issue stage uses to reserve destinations.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [5*NUM_REQ-1:0]      req_rd,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    input  logic                      resv_valid,
    input  logic [4:0]                resv_rd,
    output logic                      resv_ready,
    input  logic                      flush,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [31:0]               busy_vec,
    output logic                      rf_en,
    output logic [4:0]                rf_rd,
    output logic [DATA_W-1:0]         rf_wdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  ptr_next;
    logic [NUM_REQ-1:0] grant;
    logic              hs;
    logic [4:0]        win_rd;
    logic [DATA_W-1:0] win_wdata;
    logic              win_write;

    logic [31:0] busy_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_next;

    // Two passes give round-robin with wrap: indices at or above ptr first, then the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        hs        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hs && req_valid[i] && (PTR_W'(i) >= ptr)) begin
                grant[i]  = 1'b1;
                grant_idx = PTR_W'(i);
                hs        = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hs && req_valid[i]) begin
                grant[i]  = 1'b1;
                grant_idx = PTR_W'(i);
                hs        = 1'b1;
            end
        end
        if (!rst) begin
            grant = '0;
            hs    = 1'b0;
        end
    end

    assign req_ready = grant;

    always_comb begin
        win_rd    = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_rd    = req_rd[5*i +: 5];
                win_wdata = req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Writes to x0 are granted but never reach the register file.
    assign win_write = hs && (win_rd != 5'd0);

    always_comb begin
        ptr_next = ptr;
        if (hs) begin
            ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign resv_ready = rst && resv_valid && !flush &&
                        ((resv_rd == 5'd0) || !busy_q[resv_rd]);

    // Set beats clear on the same register; flush beats both.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (resv_ready && (resv_rd != 5'd0)) begin
            set_mask[resv_rd] = 1'b1;
        end
        if (win_write) begin
            clr_mask[win_rd] = 1'b1;
        end
        busy_next    = flush ? 32'd0 : ((busy_q & ~clr_mask) | set_mask);
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            busy_q   <= '0;
            rf_en    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            ptr    <= ptr_next;
            busy_q <= busy_next;
            rf_en  <= win_write;
            if (win_write) begin
                rf_rd    <= win_rd;
                rf_wdata <= win_wdata;
            end
        end
    end

    assign busy_vec = busy_q;
    assign rs1_busy = (rs1 != 5'd0) && busy_q[rs1];
    assign rs2_busy = (rs2 != 5'd0) && busy_q[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register-file writes are queued
// as stimulus is issued and a monitor pops them whenever rf_en pulses.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_rd;
    logic [95:0] req_wdata;
    logic        resv_valid;
    logic [4:0]  resv_rd;
    logic        resv_ready;
    logic        flush;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] busy_vec;
    logic        rf_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wdata;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_wdata(req_wdata),
        .resv_valid(resv_valid), .resv_rd(resv_rd), .resv_ready(resv_ready),
        .flush(flush), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_vec(busy_vec),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_rd     = '0;
        req_wdata  = '0;
        resv_valid = 1'b0;
        resv_rd    = '0;
        flush      = 1'b0;
        rs1        = '0;
        rs2        = '0;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] wd);
        req_valid[i]        = 1'b1;
        req_rd[5*i +: 5]    = rd;
        req_wdata[32*i +: 32] = wd;
    endtask

    task automatic set_resv(input logic [4:0] rd);
        resv_valid = 1'b1;
        resv_rd    = rd;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] wd);
        wb_t w;
        w.rd    = rd;
        w.wdata = wd;
        exp_q.push_back(w);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rf_en pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (rst && rf_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got rd=%0d wdata=0x%08h expected no write at %0t",
                         rf_rd, rf_wdata, $time);
            end else begin
                wb_t w;
                w = exp_q.pop_front();
                check_output("wb_rd", {27'd0, rf_rd}, {27'd0, w.rd});
                check_output("wb_wdata", rf_wdata, w.wdata);
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        req_valid = 3'b111;
        set_resv(5'd4);
        #12;
        check_output("reset_rf_en", {31'd0, rf_en}, 32'd0);
        check_output("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
        check_output("reset_rf_wdata", rf_wdata, 32'd0);
        check_output("reset_busy", busy_vec, 32'd0);
        check_output("reset_req_ready", {29'd0, req_ready}, 32'd0);
        check_output("reset_resv_ready", {31'd0, resv_ready}, 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();

        // Round-robin from reset: 0,1,2,0,1,2 with one write per cycle.
        set_req(0, 5'd10, 32'hA000_0000);
        set_req(1, 5'd11, 32'hA000_0001);
        set_req(2, 5'd12, 32'hA000_0002);
        for (int k = 0; k < 6; k++) begin
            expect_write(5'd10 + 5'(k % 3), 32'hA000_0000 + 32'(k % 3));
            @(negedge clk);
            check_output("rr_grant", {29'd0, req_ready}, 32'(1 << (k % 3)));
            if (k > 0) check_output("rr_rf_en", {31'd0, rf_en}, 32'd1);
            next_cycle();
        end

        // Reserve r5, then write it back from the ALU.
        clear_inputs();
        set_resv(5'd5);
        @(negedge clk);
        check_output("resv5_ready", {31'd0, resv_ready}, 32'd1);
        next_cycle();
        check_output("resv5_busy", busy_vec, 32'h0000_0020);
        rs1 = 5'd5;
        rs2 = 5'd0;
        #1;
        check_output("rs1_busy5", {31'd0, rs1_busy}, 32'd1);
        check_output("rs2_busy0", {31'd0, rs2_busy}, 32'd0);
        clear_inputs();
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        expect_write(5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        check_output("wb5_grant", {29'd0, req_ready}, 32'h1);
        next_cycle();
        check_output("wb5_busy_clear", busy_vec, 32'd0);
        clear_inputs();
        next_cycle();
        check_output("hold_rf_en", {31'd0, rf_en}, 32'd0);
        check_output("hold_rf_rd", {27'd0, rf_rd}, 32'd5);
        check_output("hold_rf_wdata", rf_wdata, 32'hDEAD_BEEF);

        // WAW on r7: blocked while pending and during its writeback cycle.
        set_resv(5'd7);
        @(negedge clk);
        check_output("resv7_first", {31'd0, resv_ready}, 32'd1);
        next_cycle();
        check_output("resv7_busy", busy_vec, 32'h0000_0080);
        @(negedge clk);
        check_output("resv7_blocked", {31'd0, resv_ready}, 32'd0);
        next_cycle();
        set_req(1, 5'd7, 32'h7777_7777);
        expect_write(5'd7, 32'h7777_7777);
        @(negedge clk);
        check_output("wb7_grant", {29'd0, req_ready}, 32'h2);
        check_output("resv7_same_cycle", {31'd0, resv_ready}, 32'd0);
        next_cycle();
        check_output("wb7_busy_clear", busy_vec, 32'd0);
        req_valid = '0;
        @(negedge clk);
        check_output("resv7_after_wb", {31'd0, resv_ready}, 32'd1);
        next_cycle();
        check_output("resv7_reset_busy", busy_vec, 32'h0000_0080);

        // Set wins over a same-cycle clear of r9; then a writeback to x0.
        clear_inputs();
        set_resv(5'd9);
        set_req(2, 5'd9, 32'h9999_9999);
        expect_write(5'd9, 32'h9999_9999);
        @(negedge clk);
        check_output("wb9_grant", {29'd0, req_ready}, 32'h4);
        check_output("resv9_ready", {31'd0, resv_ready}, 32'd1);
        next_cycle();
        check_output("set_wins_busy", busy_vec, 32'h0000_0280);
        clear_inputs();
        rs1 = 5'd9;
        rs2 = 5'd7;
        #1;
        check_output("rs1_busy9", {31'd0, rs1_busy}, 32'd1);
        check_output("rs2_busy7", {31'd0, rs2_busy}, 32'd1);
        clear_inputs();
        set_req(0, 5'd0, 32'h1234_5678);
        @(negedge clk);
        check_output("wb0_grant", {29'd0, req_ready}, 32'h1);
        next_cycle();
        check_output("wb0_rf_en", {31'd0, rf_en}, 32'd0);
        check_output("wb0_busy", busy_vec, 32'h0000_0280);

        // Flush clears all pending bits, blocks reservations, leaves writes alone.
        clear_inputs();
        flush = 1'b1;
        next_cycle();
        check_output("flush_busy", busy_vec, 32'd0);
        clear_inputs();
        for (int r = 4; r < 8; r++) begin
            set_resv(5'(r));
            @(negedge clk);
            check_output("resv_fill", {31'd0, resv_ready}, 32'd1);
            next_cycle();
        end
        check_output("fill_busy", busy_vec, 32'h0000_00F0);
        flush = 1'b1;
        set_resv(5'd3);
        set_req(1, 5'd20, 32'hF1F1_F1F1);
        expect_write(5'd20, 32'hF1F1_F1F1);
        @(negedge clk);
        check_output("flush_resv_ready", {31'd0, resv_ready}, 32'd0);
        check_output("flush_grant", {29'd0, req_ready}, 32'h2);
        next_cycle();
        check_output("flush_busy2", busy_vec, 32'd0);

        // Reset mid-burst: the in-flight write is lost, pointer restarts at 0.
        clear_inputs();
        set_req(0, 5'd21, 32'hA1A1_A1A1);
        set_req(1, 5'd22, 32'hA2A2_A2A2);
        set_req(2, 5'd23, 32'hA3A3_A3A3);
        set_resv(5'd3);
        expect_write(5'd23, 32'hA3A3_A3A3);
        @(negedge clk);
        check_output("burst_grant2", {29'd0, req_ready}, 32'h4);
        next_cycle();
        expect_write(5'd21, 32'hA1A1_A1A1);
        @(negedge clk);
        check_output("burst_grant0", {29'd0, req_ready}, 32'h1);
        next_cycle();
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_output("midrst_rf_en", {31'd0, rf_en}, 32'd0);
        check_output("midrst_rf_rd", {27'd0, rf_rd}, 32'd0);
        check_output("midrst_rf_wdata", rf_wdata, 32'd0);
        check_output("midrst_busy", busy_vec, 32'd0);
        check_output("midrst_req_ready", {29'd0, req_ready}, 32'd0);
        check_output("midrst_resv_ready", {31'd0, resv_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();
        set_req(0, 5'd24, 32'hB0B0_B0B0);
        set_req(2, 5'd25, 32'hB2B2_B2B2);
        expect_write(5'd24, 32'hB0B0_B0B0);
        @(negedge clk);
        check_output("post_rst_rf_en", {31'd0, rf_en}, 32'd0);
        check_output("post_rst_grant", {29'd0, req_ready}, 32'h1);
        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
        check_output("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
